window_mult_sched: RTL and testbench

//  Sequences an AXI-stream of complex int samples through the pipelined complex_int_mult

---
 rtl/window_mult_sched.sv | 120 ++++++++++++
 tb/tb_window_mult_sched.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_mult_sched.sv
// Windowing scheduler: pairs stream samples with ROM coefficients; results emerge PIPE_NUM enabled cycles later.
// Backpressure: m_tready low with m_tvalid high freezes the multiplier pipe and tags, and drops s_tready.
package axis_pkg;
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } sample_t_int;
endpackage

module window_mult_sched
  import axis_pkg::*;
#(
  parameter int PIPE_NUM  = 10,
  parameter int FRAME_LEN = 1024,
  parameter int SYMMETRIC = 0,
  localparam int ADDR_W   = (SYMMETRIC != 0) ? $clog2(FRAME_LEN) - 1 : $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  sample_t_int       s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [ADDR_W-1:0] coef_addr,
  input  sample_t_int       coef_data,
  output logic              mult_en,
  output sample_t_int       mult_a,
  output sample_t_int       mult_b,
  input  sample_t_int       mult_z,
  output sample_t_int       m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(FRAME_LEN / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PIPE_NUM-1:0] vld_sr_q, vld_sr_d;
  logic [PIPE_NUM-1:0] last_sr_q, last_sr_d;
  logic                frame_err_q, frame_err_d;
  logic                accept;
  logic                at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vld_sr_q    <= vld_sr_d;
      last_sr_q   <= last_sr_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    mult_en  = ~(vld_sr_q[PIPE_NUM-1] & ~m_tready);
    s_tready = mult_en & (state_q == RUN);
    accept   = s_tvalid & s_tready;
    at_max   = (cnt_q == CNT_MAX);

    // A tlast or a full count both close the frame, so a bad length resyncs on the next sample.
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = (s_tlast | at_max) ? '0 : cnt_q + 1'b1;
    end
    frame_err_d = accept & (s_tlast ^ at_max);

    vld_sr_d  = vld_sr_q;
    last_sr_d = last_sr_q;
    if (mult_en) begin
      vld_sr_d  = (vld_sr_q << 1) | PIPE_NUM'(accept);
      last_sr_d = (last_sr_q << 1) | PIPE_NUM'(accept & s_tlast);
    end

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_en) state_d = RUN;
      RUN:     if (!cfg_en && (cnt_d == '0)) state_d = DRAIN;
      DRAIN:   if (vld_sr_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  generate
    if (SYMMETRIC != 0) begin : g_sym
      logic [CNT_W-1:0] mirror;
      assign mirror    = CNT_MAX - cnt_q;
      assign coef_addr = (cnt_q < CNT_HALF) ? cnt_q[ADDR_W-1:0] : mirror[ADDR_W-1:0];
    end else begin : g_full
      assign coef_addr = cnt_q;
    end
  endgenerate

  assign mult_a    = s_tdata;
  assign mult_b    = coef_data;
  assign m_tdata   = mult_z;
  assign m_tvalid  = vld_sr_q[PIPE_NUM-1];
  assign m_tlast   = last_sr_q[PIPE_NUM-1];
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_window_mult_sched.sv
// Bench: two scheduler instances (full and mirrored ROM) on one stream, each with a ROM and multiplier stand-in.
module tb_window_mult_sched;
  import axis_pkg::*;

  localparam int P  = 4;
  localparam int L  = 8;
  localparam int A0 = 3;
  localparam int A1 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_en = 1'b0;
  sample_t_int s_tdata = '0;
  logic s_tvalid = 1'b0;
  logic s_tlast = 1'b0;
  logic m_tready = 1'b0;

  logic s_tready0, s_tready1, mult_en0, mult_en1, m_tvalid0, m_tvalid1;
  logic m_tlast0, m_tlast1, frame_err0, frame_err1, busy0, busy1;
  logic [A0-1:0] coef_addr0;
  logic [A1-1:0] coef_addr1;
  sample_t_int coef_data0, coef_data1, mult_a0, mult_a1, mult_b0, mult_b1;
  sample_t_int mult_z0, mult_z1, m_tdata0, m_tdata1;

  sample_t_int rom0 [L];
  sample_t_int rom1 [L/2];
  sample_t_int mp0 [P];
  sample_t_int mp1 [P];

  window_mult_sched #(.PIPE_NUM(P), .FRAME_LEN(L), .SYMMETRIC(0)) u_dut0 (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready0), .coef_addr(coef_addr0), .coef_data(coef_data0),
    .mult_en(mult_en0), .mult_a(mult_a0), .mult_b(mult_b0), .mult_z(mult_z0),
    .m_tdata(m_tdata0), .m_tvalid(m_tvalid0), .m_tlast(m_tlast0), .m_tready(m_tready),
    .frame_err(frame_err0), .busy(busy0));

  window_mult_sched #(.PIPE_NUM(P), .FRAME_LEN(L), .SYMMETRIC(1)) u_dut1 (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready1), .coef_addr(coef_addr1), .coef_data(coef_data1),
    .mult_en(mult_en1), .mult_a(mult_a1), .mult_b(mult_b1), .mult_z(mult_z1),
    .m_tdata(m_tdata1), .m_tvalid(m_tvalid1), .m_tlast(m_tlast1), .m_tready(m_tready),
    .frame_err(frame_err1), .busy(busy1));

  always #5 clk = ~clk;

  function automatic sample_t_int cmul(sample_t_int a, sample_t_int b);
    int re;
    int im;
    sample_t_int r;
    re = int'(a.re) * int'(b.re) - int'(a.im) * int'(b.im);
    im = int'(a.re) * int'(b.im) + int'(a.im) * int'(b.re);
    r.re = re[15:0];
    r.im = im[15:0];
    return r;
  endfunction

  function automatic int mir(int p);
    return (p < L / 2) ? p : L - 1 - p;
  endfunction

  // Async ROMs and the multiplier stand-in (product enters when enabled, leaves P enabled cycles later).
  assign coef_data0 = rom0[coef_addr0];
  assign coef_data1 = rom1[coef_addr1];
  assign mult_z0 = mp0[P-1];
  assign mult_z1 = mp1[P-1];

  always @(posedge clk) begin
    if (mult_en0) begin
      mp0[0] <= cmul(mult_a0, mult_b0);
      for (int i = 1; i < P; i++) mp0[i] <= mp0[i-1];
    end
    if (mult_en1) begin
      mp1[0] <= cmul(mult_a1, mult_b1);
      for (int i = 1; i < P; i++) mp1[i] <= mp1[i-1];
    end
  end

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight items carry their age in enabled cycles; age P means presented.
  typedef struct {
    sample_t_int d0;
    sample_t_int d1;
    bit          last;
    int          age;
  } item_t;

  item_t items[$];
  int    m_mode = 0;
  int    m_pos = 0;
  bit    m_err = 1'b0;
  bit    acc_m = 1'b0;
  int    cyc = 0;

  always @(posedge clk) begin
    bit mv;
    bit en;
    bit acc;
    bit empty0;
    int nxt;
    item_t it;
    cyc++;
    if (rst) begin
      items.delete();
      m_mode = 0;
      m_pos = 0;
      m_err = 1'b0;
      acc_m = 1'b0;
    end else begin
      mv = (items.size() > 0) && (items[0].age == P);
      en = !(mv && !m_tready);
      acc = s_tvalid && en && (m_mode == 1);
      empty0 = (items.size() == 0);
      acc_m = acc;
      m_err = acc && (s_tlast != (m_pos == L - 1));
      nxt = m_pos;
      if (acc) nxt = (s_tlast || m_pos == L - 1) ? 0 : m_pos + 1;
      if (en) begin
        if (mv) void'(items.pop_front());
        foreach (items[i]) items[i].age++;
        if (acc) begin
          it.d0 = cmul(s_tdata, rom0[m_pos]);
          it.d1 = cmul(s_tdata, rom1[mir(m_pos)]);
          it.last = s_tlast;
          it.age = 1;
          items.push_back(it);
        end
      end
      case (m_mode)
        0:       if (cfg_en) m_mode = 1;
        1:       if (!cfg_en && nxt == 0) m_mode = 2;
        default: if (empty0) m_mode = 0;
      endcase
      m_pos = nxt;
    end
  end

  // Source and sink drivers.
  sample_t_int src_d[$];
  bit          src_l[$];
  int vld_pct = 100;
  int rdy_pct = 100;
  int flush_gen = 0;
  int flush_seen = 0;

  always @(posedge clk) begin
    #1;
    if (acc_m) s_tvalid = 1'b0;
    if (flush_gen != flush_seen) begin
      s_tvalid = 1'b0;
      flush_seen = flush_gen;
    end
    if (!s_tvalid) begin
      s_tdata = $urandom;
      s_tlast = 1'($urandom_range(1));
      if (src_d.size() > 0 && $urandom_range(99) < vld_pct) begin
        s_tdata = src_d.pop_front();
        s_tlast = src_l.pop_front();
        s_tvalid = 1'b1;
      end
    end
    m_tready = ($urandom_range(99) < rdy_pct);
  end

  // Per-cycle compare plus observation logs for the directed checks.
  int          acc_a0[$];
  int          acc_a1[$];
  logic [32:0] out_log[$];
  int          err_cnt = 0;
  int          first_acc = -1;
  int          first_val = -1;

  always @(negedge clk) begin
    bit mv;
    bit en;
    bit srdy;
    if (chk_on) begin
      mv = (items.size() > 0) && (items[0].age == P);
      en = !(mv && !m_tready);
      srdy = en && (m_mode == 1);
      chk("mult_en0", 64'(mult_en0), 64'(en));
      chk("mult_en1", 64'(mult_en1), 64'(en));
      chk("s_tready0", 64'(s_tready0), 64'(srdy));
      chk("s_tready1", 64'(s_tready1), 64'(srdy));
      chk("m_tvalid0", 64'(m_tvalid0), 64'(mv));
      chk("m_tvalid1", 64'(m_tvalid1), 64'(mv));
      chk("m_tlast0", 64'(m_tlast0), 64'(mv ? items[0].last : 1'b0));
      chk("m_tlast1", 64'(m_tlast1), 64'(mv ? items[0].last : 1'b0));
      chk("coef_addr0", 64'(coef_addr0), 64'(m_pos));
      chk("coef_addr1", 64'(coef_addr1), 64'(mir(m_pos)));
      chk("frame_err0", 64'(frame_err0), 64'(m_err));
      chk("frame_err1", 64'(frame_err1), 64'(m_err));
      chk("busy0", 64'(busy0), 64'(m_mode != 0));
      chk("busy1", 64'(busy1), 64'(m_mode != 0));
      chk("mult_a0", 64'(mult_a0), 64'(s_tdata));
      chk("mult_b0", 64'(mult_b0), 64'(rom0[m_pos]));
      chk("mult_b1", 64'(mult_b1), 64'(rom1[mir(m_pos)]));
      if (mv) begin
        chk("m_tdata0", 64'(m_tdata0), 64'(items[0].d0));
        chk("m_tdata1", 64'(m_tdata1), 64'(items[0].d1));
      end
      if (s_tvalid && s_tready0) begin
        acc_a0.push_back(int'(coef_addr0));
        acc_a1.push_back(int'(coef_addr1));
        if (first_acc < 0) first_acc = cyc;
      end
      if (m_tvalid0 && first_val < 0) first_val = cyc;
      if (m_tvalid0 && m_tready) out_log.push_back({m_tlast0, m_tdata0});
      if (frame_err0) err_cnt++;
    end
  end

  task automatic clear_logs();
    acc_a0.delete();
    acc_a1.delete();
    out_log.delete();
    err_cnt = 0;
    first_acc = -1;
    first_val = -1;
  endtask

  task automatic push_frame(int n, bit with_last, int base, bit ramp);
    sample_t_int s;
    for (int k = 0; k < n; k++) begin
      if (ramp) begin
        s.re = 16'(base + k);
        s.im = 16'sd0;
      end else begin
        s = $urandom;
      end
      src_d.push_back(s);
      src_l.push_back(with_last && (k == n - 1));
    end
  endtask

  task automatic wait_out(int n, int budget, string name);
    int c = 0;
    while (out_log.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(name, 64'(out_log.size() >= n), 64'(1));
  endtask

  task automatic wait_acc(int n, int budget, string name);
    int c = 0;
    while (acc_a0.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(name, 64'(acc_a0.size() >= n), 64'(1));
  endtask

  task automatic wait_idle(int budget, string name);
    int c = 0;
    @(negedge clk);
    while (busy0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(name, 64'(busy0), 64'(0));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int sym_exp[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
    sample_t_int unity;
    unity.re = 16'sd1;
    unity.im = 16'sd0;
    foreach (rom0[i]) rom0[i] = unity;
    foreach (rom1[i]) rom1[i] = unity;

    // Reset state.
    repeat (3) @(posedge clk);
    #2 chk_on = 1'b1;
    @(negedge clk);
    chk("rst_s_tready", 64'(s_tready0), 64'(0));
    chk("rst_m_tvalid", 64'(m_tvalid0), 64'(0));
    chk("rst_m_tlast", 64'(m_tlast0), 64'(0));
    chk("rst_busy", 64'(busy0), 64'(0));
    chk("rst_coef_addr", 64'(coef_addr0), 64'(0));
    chk("rst_frame_err", 64'(frame_err0), 64'(0));

    // Two back-to-back ramp frames through unity coefficients.
    step();
    rst = 1'b0;
    cfg_en = 1'b1;
    clear_logs();
    push_frame(8, 1'b1, 0, 1'b1);
    push_frame(8, 1'b1, 8, 1'b1);
    wait_out(16, 200, "t1_outputs");
    chk("t1_latency", 64'(first_val - first_acc), 64'(P));
    for (int i = 0; i < 16; i++) begin
      chk("t1_re", 64'(out_log[i][31:16]), 64'(i));
      chk("t1_im", 64'(out_log[i][15:0]), 64'(0));
      chk("t1_last", 64'(out_log[i][32]), 64'(i % 8 == 7));
      chk("t1_addr_full", 64'(acc_a0[i]), 64'(i % 8));
      chk("t3_addr_sym", 64'(acc_a1[i]), 64'(sym_exp[i % 8]));
    end

    // Three-cycle sink stall mid-frame.
    step();
    clear_logs();
    push_frame(8, 1'b1, 0, 1'b1);
    wait_out(2, 100, "t2_start");
    rdy_pct = 0;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("t2_stall_en", 64'(mult_en0), 64'(0));
      chk("t2_stall_srdy", 64'(s_tready0), 64'(0));
      chk("t2_stall_vld", 64'(m_tvalid0), 64'(1));
    end
    rdy_pct = 100;
    wait_out(8, 100, "t2_outputs");
    repeat (10) @(negedge clk);
    chk("t2_count", 64'(out_log.size()), 64'(8));
    for (int i = 0; i < 8; i++) begin
      chk("t2_re", 64'(out_log[i][31:16]), 64'(i));
      chk("t2_last", 64'(out_log[i][32]), 64'(i == 7));
    end

    // Short frame, then a frame missing its tlast, then a good frame.
    step();
    clear_logs();
    push_frame(5, 1'b1, 0, 1'b1);
    push_frame(8, 1'b0, 0, 1'b1);
    push_frame(8, 1'b1, 0, 1'b1);
    wait_out(21, 200, "t4_outputs");
    chk("t4_err_count", 64'(err_cnt), 64'(2));
    chk("t4_addr_short_end", 64'(acc_a0[4]), 64'(4));
    chk("t4_addr_after_short", 64'(acc_a0[5]), 64'(0));
    chk("t4_addr_full_end", 64'(acc_a0[12]), 64'(7));
    chk("t4_addr_wrap", 64'(acc_a0[13]), 64'(0));

    // Randomized traffic, coefficients, backpressure and enable toggling.
    vld_pct = 70;
    rdy_pct = 60;
    for (int c = 0; c < 1500; c++) begin
      step();
      if (c % 300 == 0) begin
        foreach (rom0[i]) rom0[i] = $urandom;
        foreach (rom1[i]) rom1[i] = $urandom;
      end
      if (src_d.size() < 16) begin
        if ($urandom_range(4) != 0) push_frame(8, 1'b1, 0, 1'b0);
        else push_frame(int'($urandom_range(12, 1)), 1'($urandom_range(1)), 0, 1'b0);
      end
      if ($urandom_range(199) == 0) cfg_en = !cfg_en;
    end
    push_frame(1, 1'b1, 0, 1'b0);
    cfg_en = 1'b0;
    wait_idle(3000, "rand_drain");
    step();
    flush_gen++;
    src_d.delete();
    src_l.delete();
    foreach (rom0[i]) rom0[i] = unity;
    foreach (rom1[i]) rom1[i] = unity;

    // Enable dropped mid-frame: frame completes, then nothing more is taken.
    step();
    clear_logs();
    vld_pct = 100;
    rdy_pct = 70;
    cfg_en = 1'b1;
    push_frame(8, 1'b1, 0, 1'b1);
    push_frame(8, 1'b1, 8, 1'b1);
    wait_acc(3, 100, "t5_start");
    step();
    cfg_en = 1'b0;
    wait_idle(300, "t5_idle");
    repeat (20) @(negedge clk);
    chk("t5_accepts", 64'(acc_a0.size()), 64'(8));
    chk("t5_last_addr", 64'(acc_a0[7]), 64'(7));
    chk("t5_outputs", 64'(out_log.size()), 64'(8));
    chk("t5_srdy", 64'(s_tready0), 64'(0));

    // Reset with samples in flight.
    step();
    flush_gen++;
    src_d.delete();
    src_l.delete();
    rdy_pct = 100;
    cfg_en = 1'b1;
    step();
    clear_logs();
    push_frame(8, 1'b1, 0, 1'b1);
    wait_acc(3, 100, "t6_start");
    step();
    rst = 1'b1;
    flush_gen++;
    src_d.delete();
    src_l.delete();
    @(posedge clk);
    @(negedge clk);
    chk("t6_m_tvalid", 64'(m_tvalid0), 64'(0));
    chk("t6_busy", 64'(busy0), 64'(0));
    chk("t6_coef_addr", 64'(coef_addr0), 64'(0));
    clear_logs();
    step();
    rst = 1'b0;
    push_frame(8, 1'b1, 100, 1'b1);
    wait_out(8, 200, "t6_outputs");
    repeat (10) @(negedge clk);
    chk("t6_count", 64'(out_log.size()), 64'(8));
    chk("t6_first_addr", 64'(acc_a0[0]), 64'(0));
    chk("t6_first_re", 64'(out_log[0][31:16]), 64'(100));
    chk("t6_last", 64'(out_log[7][32]), 64'(1));

    step();
    cfg_en = 1'b0;
    wait_idle(200, "final_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
